// File: rtl/intra4x4_scan_ctrl_if.sv
// Handshake bundle between the 4x4 scan controller, the luma extractor and the
// intra-prediction engine. The master modport is the controller's side.
interface intra4x4_scan_ctrl_if #(
  parameter int IDX_W = 13
);
  logic             start;
  logic             abort;
  logic             ext_enable;
  logic [IDX_W-1:0] ext_mbnumber;
  logic             blk_valid;
  logic             blk_ready;
  logic [IDX_W-1:0] blk_index;
  logic             pred_done;
  logic             busy;
  logic             frame_done;

  modport master (
    input  start, abort, blk_ready, pred_done,
    output ext_enable, ext_mbnumber, blk_valid, blk_index, busy, frame_done
  );

  modport slave (
    output start, abort, blk_ready, pred_done,
    input  ext_enable, ext_mbnumber, blk_valid, blk_index, busy, frame_done
  );
endinterface

// File: rtl/intra4x4_scan_ctrl.sv
// Frame sequencer: per 4x4 block, run the extractor, offer the block to the
// predictor over valid/ready, then wait for its completion pulse.
module intra4x4_scan_ctrl #(
  parameter int NUM_BLOCKS  = 4096,
  parameter int EXTRACT_LAT = 3,
  parameter int IDX_W       = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  intra4x4_scan_ctrl_if.master  bus
);

  typedef enum logic [2:0] {IDLE, FETCH, PRESENT, PREDICT, DONE} state_e;

  localparam int               LAT_W    = (EXTRACT_LAT > 1) ? $clog2(EXTRACT_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(EXTRACT_LAT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             ext_en_q, ext_en_d;
  logic [IDX_W-1:0] mbnum_q, mbnum_d;
  logic             blk_valid_q, blk_valid_d;
  logic [IDX_W-1:0] blk_index_q, blk_index_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  // Outputs are computed one state ahead so every output is a flop.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lat_d        = lat_q;
    ext_en_d     = ext_en_q;
    mbnum_d      = mbnum_q;
    blk_valid_d  = blk_valid_q;
    blk_index_d  = blk_index_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    if (bus.abort) begin
      state_d     = IDLE;
      idx_d       = '0;
      lat_d       = '0;
      ext_en_d    = 1'b0;
      mbnum_d     = '0;
      blk_valid_d = 1'b0;
      blk_index_d = '0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_d  = FETCH;
          idx_d    = '0;
          lat_d    = '0;
          busy_d   = 1'b1;
          ext_en_d = 1'b1;
          mbnum_d  = '0;
        end
        FETCH: begin
          if (lat_q == LAST_LAT) begin
            state_d     = PRESENT;
            ext_en_d    = 1'b0;
            blk_valid_d = 1'b1;
            blk_index_d = idx_q;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
        PRESENT: if (bus.blk_ready) begin
          state_d     = PREDICT;
          blk_valid_d = 1'b0;
        end
        PREDICT: if (bus.pred_done) begin
          if (idx_q == LAST_IDX) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d  = FETCH;
            idx_d    = idx_q + IDX_W'(1);
            lat_d    = '0;
            ext_en_d = 1'b1;
            mbnum_d  = idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          idx_d       = '0;
          mbnum_d     = '0;
          blk_index_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      lat_q        <= '0;
      ext_en_q     <= 1'b0;
      mbnum_q      <= '0;
      blk_valid_q  <= 1'b0;
      blk_index_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      ext_en_q     <= ext_en_d;
      mbnum_q      <= mbnum_d;
      blk_valid_q  <= blk_valid_d;
      blk_index_q  <= blk_index_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.ext_enable   = ext_en_q;
  assign bus.ext_mbnumber = mbnum_q;
  assign bus.blk_valid    = blk_valid_q;
  assign bus.blk_index    = blk_index_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;

endmodule
